// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_ctrl
//  Purpose  : Direct-mapped, write-back, write-allocate data cache controller
//             sitting between the CPU load/store path and word-addressed
//             main memory. One data word per line. Hits complete in the
//             request cycle. Misses stall the CPU while an optional dirty-victim
//             write-back cycle and a single fetch cycle refill the line.
//             Word address 0xFC is an uncached MMIO read passed to memory.
//  Ports    : clk, rst_n           - clock, asynchronous active-low reset
//             cpu_re/cpu_we        - load / store request (store wins)
//             cpu_addr/cpu_wdata   - request word address / store data
//             cpu_rdata            - load data (hit or MMIO), else zero
//             stall                - CPU must hold its request
//             mem_fetch/mem_addr   - line fetch strobe / read address
//             mem_rd               - combinational memory read data
//             mem_writeback        - victim write strobe (write at next edge)
//             mem_wb_addr/_data    - victim address / data
//  Revision : 1.0 - initial release
// ============================================================================
module dcache_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_re,
    input  logic                  cpu_we,
    input  logic [DATA_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  stall,
    output logic                  mem_fetch,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd,
    output logic                  mem_writeback,
    output logic [DATA_WIDTH-1:0] mem_wb_addr,
    output logic [DATA_WIDTH-1:0] mem_wb_data
);

    localparam int TAG_BITS = DATA_WIDTH - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;
    localparam logic [DATA_WIDTH-1:0] c_MMIO_ADDR = DATA_WIDTH'(8'hFC);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_FETCH     = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Line state: valid/dirty need reset, tag/data storage does not.
    logic [LINES-1:0]      valid_q;
    logic [LINES-1:0]      dirty_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [DATA_WIDTH-1:0] data_q [LINES];

    logic mem_fetch_q;
    logic mem_writeback_q;

    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_BITS-1:0]   w_tag;
    logic [TAG_BITS-1:0]   w_line_tag;
    logic [DATA_WIDTH-1:0] w_line_data;
    logic                  w_idle;
    logic                  w_req;
    logic                  w_load;
    logic                  w_mmio;
    logic                  w_hit;
    logic                  w_miss;
    logic                  w_store_hit;
    logic                  w_victim_dirty;

    assign w_index     = cpu_addr[INDEX_BITS-1:0];
    assign w_tag       = cpu_addr[DATA_WIDTH-1:INDEX_BITS];
    assign w_line_tag  = tag_q[w_index];
    assign w_line_data = data_q[w_index];

    assign w_idle = (state_q == S_IDLE);
    assign w_req  = cpu_re | cpu_we;
    assign w_load = cpu_re & ~cpu_we;
    assign w_mmio = (cpu_addr == c_MMIO_ADDR);
    assign w_hit  = valid_q[w_index] && (w_line_tag == w_tag);

    // The MMIO word never enters the cache, so it is neither a hit nor a miss.
    assign w_miss         = w_idle & w_req & ~w_mmio & ~w_hit;
    assign w_store_hit    = w_idle & cpu_we & ~w_mmio & w_hit;
    assign w_victim_dirty = valid_q[w_index] & dirty_q[w_index];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (w_miss) state_d = w_victim_dirty ? S_WRITEBACK : S_FETCH;
            S_WRITEBACK: state_d = S_FETCH;
            S_FETCH:     state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Control FSM with registered memory strobes; strobes track the next state
    // so they are high exactly during the WRITEBACK / FETCH cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            valid_q         <= '0;
            dirty_q         <= '0;
            mem_fetch_q     <= 1'b0;
            mem_writeback_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            mem_fetch_q     <= (state_d == S_FETCH);
            mem_writeback_q <= (state_d == S_WRITEBACK);
            case (state_q)
                S_WRITEBACK: dirty_q[w_index] <= 1'b0;
                S_FETCH: begin
                    valid_q[w_index] <= 1'b1;
                    dirty_q[w_index] <= 1'b0;
                end
                default: if (w_store_hit) dirty_q[w_index] <= 1'b1;
            endcase
        end
    end

    // Line storage. A store that missed completes on the IDLE cycle after the
    // refill, where it is then a store hit (write-allocate).
    always_ff @(posedge clk) begin
        if (state_q == S_FETCH) begin
            data_q[w_index] <= mem_rd;
            tag_q[w_index]  <= w_tag;
        end else if (w_store_hit) begin
            data_q[w_index] <= cpu_wdata;
        end
    end

    // Stall is forced low while reset is asserted even if a missing request is
    // still being presented.
    assign stall         = rst_n & (~w_idle | w_miss);
    assign mem_fetch     = mem_fetch_q;
    assign mem_writeback = mem_writeback_q;
    assign mem_addr      = cpu_addr;
    assign mem_wb_addr   = mem_writeback_q ? {w_line_tag, w_index} : '0;
    assign mem_wb_data   = mem_writeback_q ? w_line_data : '0;

    always_comb begin
        cpu_rdata = '0;
        if (w_idle && w_load) begin
            if (w_mmio)     cpu_rdata = mem_rd;
            else if (w_hit) cpu_rdata = w_line_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcache_ctrl
//  Purpose  : Self-checking bench for dcache_ctrl. A word memory model drives
//             mem_rd and absorbs write-backs; a transaction-level cache model
//             predicts stall counts, write-back traffic and load data.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_re, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        stall, mem_fetch, mem_writeback;
    logic [31:0] mem_addr, mem_rd, mem_wb_addr, mem_wb_data;

    int n_cmp  = 0;
    int n_fail = 0;

    dcache_ctrl #(.DATA_WIDTH(32), .INDEX_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_re(cpu_re), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .stall(stall), .mem_fetch(mem_fetch), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_writeback(mem_writeback), .mem_wb_addr(mem_wb_addr), .mem_wb_data(mem_wb_data)
    );

    always #5 clk = ~clk;

    // ---------------- memory seen by the DUT ----------------
    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    int mem_gen = 0;
    int pre_gen = 0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction
    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction
    function automatic logic [31:0] rd_ref(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    always begin
        mem_rd = rd_mem(mem_addr);
        @(mem_addr or mem_gen or pre_gen);
    end

    always @(posedge clk) begin
        if (rst_n === 1'b1 && mem_writeback === 1'b1) begin
            mem[mem_wb_addr] = mem_wb_data;
            mem_gen++;
        end
    end

    // ---------------- transaction-level cache model ----------------
    bit          ref_valid [256];
    bit          ref_dirty [256];
    logic [31:0] ref_tag   [256];
    logic [31:0] ref_data  [256];

    function automatic void ref_clear();
        for (int i = 0; i < 256; i++) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
        end
    endfunction

    function automatic void ref_access(input logic we, input logic re,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       output int e_st, output int e_wb,
                                       output logic [31:0] e_wba, output logic [31:0] e_wbd,
                                       output logic [31:0] e_rd);
        int          idx;
        logic [31:0] tg;
        e_st = 0; e_wb = 0; e_wba = '0; e_wbd = '0; e_rd = '0;
        if (!we && !re) return;
        if (addr == 32'hFC) begin
            if (!we) e_rd = rd_ref(addr);
            return;
        end
        idx = int'(addr % 32'd256);
        tg  = addr / 32'd256;
        if (!(ref_valid[idx] && ref_tag[idx] == tg)) begin
            if (ref_valid[idx] && ref_dirty[idx]) begin
                e_wb  = 1;
                e_wba = ref_tag[idx] * 32'd256 + 32'(idx);
                e_wbd = ref_data[idx];
                ref_mem[e_wba] = e_wbd;
                e_st = 3;
            end else begin
                e_st = 2;
            end
            ref_data[idx]  = rd_ref(addr);
            ref_tag[idx]   = tg;
            ref_valid[idx] = 1'b1;
            ref_dirty[idx] = 1'b0;
        end
        if (we) begin
            ref_data[idx]  = wdata;
            ref_dirty[idx] = 1'b1;
        end else begin
            e_rd = ref_data[idx];
        end
    endfunction

    // ---------------- driver / observer ----------------
    // Called just after a posedge; returns just after the posedge that
    // completes the access, with the request dropped.
    task automatic do_access(input logic we, input logic re,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output int st, output int wbs,
                             output logic [31:0] wba, output logic [31:0] wbd,
                             output int fch, output bit fok, output bit both,
                             output logic [31:0] rdata);
        int fidx;
        bit done;
        st = 0; wbs = 0; wba = '0; wbd = '0; fch = 0; fok = 1'b1; both = 1'b0;
        rdata = '0; fidx = -1; done = 1'b0;
        cpu_we = we; cpu_re = re; cpu_addr = addr; cpu_wdata = wdata;
        while (!done) begin
            @(negedge clk);
            if (mem_writeback === 1'b1) begin wbs++; wba = mem_wb_addr; wbd = mem_wb_data; end
            if (mem_fetch === 1'b1) begin fch++; fidx = st; if (mem_addr !== addr) fok = 1'b0; end
            if (mem_writeback === 1'b1 && mem_fetch === 1'b1) both = 1'b1;
            if (stall !== 1'b1) done = 1'b1;
            else begin
                st++;
                if (st > 10) done = 1'b1;
                else begin @(posedge clk); #1; end
            end
        end
        rdata = cpu_rdata;
        if (fch > 0 && fidx != st - 1) fok = 1'b0;
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_re = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] a;
        rst_n = 1'b0; cpu_re = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
        n_cmp++; if (mem_fetch !== 1'b0) begin n_fail++; $display("FAIL reset_fetch: got %b expected 0", mem_fetch); end
        n_cmp++; if (mem_writeback !== 1'b0) begin n_fail++; $display("FAIL reset_wb: got %b expected 0", mem_writeback); end
        @(negedge clk); rst_n = 1'b1;
        ref_clear();
        a = $urandom;
        cpu_addr = a;
        @(posedge clk); #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL idle_stall: got %b expected 0", stall); end
        n_cmp++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL idle_rdata: got %h expected 0", cpu_rdata); end
        n_cmp++; if (mem_addr !== a) begin n_fail++; $display("FAIL idle_mem_addr: got %h expected %h", mem_addr, a); end
        n_cmp++; if (mem_wb_addr !== 32'h0 || mem_wb_data !== 32'h0) begin n_fail++; $display("FAIL idle_wb_bus: got %h/%h expected 0/0", mem_wb_addr, mem_wb_data); end
    endtask

    task automatic test_load_miss_clean();
        int st, wbs, fch, e_st, e_wb; bit fok, both; logic [31:0] wba, wbd, rd, e_wba, e_wbd, e_rd;
        ref_access(0, 1, 32'h00010000, 0, e_st, e_wb, e_wba, e_wbd, e_rd);
        do_access(0, 1, 32'h00010000, 0, st, wbs, wba, wbd, fch, fok, both, rd);
        n_cmp++; if (st !== 2) begin n_fail++; $display("FAIL clean_miss_stalls: got %0d expected 2", st); end
        n_cmp++; if (fch !== 1 || !fok) begin n_fail++; $display("FAIL clean_miss_fetch: got count %0d ok %0d expected 1/1", fch, fok); end
        n_cmp++; if (wbs !== 0) begin n_fail++; $display("FAIL clean_miss_wb: got %0d expected 0", wbs); end
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL clean_miss_rdata: got %h expected deadbeef", rd); end
        ref_access(0, 1, 32'h00010000, 0, e_st, e_wb, e_wba, e_wbd, e_rd);
        do_access(0, 1, 32'h00010000, 0, st, wbs, wba, wbd, fch, fok, both, rd);
        n_cmp++; if (st !== 0 || fch !== 0) begin n_fail++; $display("FAIL reload_hit: got stalls %0d fetches %0d expected 0/0", st, fch); end
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL reload_rdata: got %h expected deadbeef", rd); end
    endtask

    task automatic test_store_hit();
        int st, wbs, fch, e_st, e_wb; bit fok, both; logic [31:0] wba, wbd, rd, e_wba, e_wbd, e_rd;
        ref_access(1, 0, 32'h00010000, 32'h12345678, e_st, e_wb, e_wba, e_wbd, e_rd);
        do_access(1, 0, 32'h00010000, 32'h12345678, st, wbs, wba, wbd, fch, fok, both, rd);
        n_cmp++; if (st !== 0 || wbs !== 0 || fch !== 0) begin n_fail++; $display("FAIL store_hit_traffic: got stalls %0d wb %0d fetch %0d expected 0/0/0", st, wbs, fch); end
        ref_access(0, 1, 32'h00010000, 0, e_st, e_wb, e_wba, e_wbd, e_rd);
        do_access(0, 1, 32'h00010000, 0, st, wbs, wba, wbd, fch, fok, both, rd);
        n_cmp++; if (rd !== 32'h12345678 || st !== 0) begin n_fail++; $display("FAIL store_hit_readback: got %h stalls %0d expected 12345678/0", rd, st); end
    endtask

    task automatic test_dirty_evict();
        int st, wbs, fch, e_st, e_wb; bit fok, both; logic [31:0] wba, wbd, rd, e_wba, e_wbd, e_rd;
        ref_access(0, 1, 32'h00010100, 0, e_st, e_wb, e_wba, e_wbd, e_rd);
        do_access(0, 1, 32'h00010100, 0, st, wbs, wba, wbd, fch, fok, both, rd);
        n_cmp++; if (st !== 3) begin n_fail++; $display("FAIL dirty_miss_stalls: got %0d expected 3", st); end
        n_cmp++; if (wbs !== 1 || wba !== 32'h00010000 || wbd !== 32'h12345678) begin n_fail++; $display("FAIL dirty_miss_wb: got n %0d addr %h data %h expected 1/00010000/12345678", wbs, wba, wbd); end
        n_cmp++; if (fch !== 1 || !fok || both) begin n_fail++; $display("FAIL dirty_miss_fetch: got n %0d ok %0d overlap %0d expected 1/1/0", fch, fok, both); end
        n_cmp++; if (rd !== e_rd) begin n_fail++; $display("FAIL dirty_miss_rdata: got %h expected %h", rd, e_rd); end
        n_cmp++; if (rd_mem(32'h00010000) !== 32'h12345678) begin n_fail++; $display("FAIL dirty_miss_memory: got %h expected 12345678", rd_mem(32'h00010000)); end
    endtask

    task automatic test_store_miss();
        int st, wbs, fch, e_st, e_wb; bit fok, both; logic [31:0] wba, wbd, rd, e_wba, e_wbd, e_rd;
        ref_access(1, 0, 32'h00010005, 32'hCAFEF00D, e_st, e_wb, e_wba, e_wbd, e_rd);
        do_access(1, 0, 32'h00010005, 32'hCAFEF00D, st, wbs, wba, wbd, fch, fok, both, rd);
        n_cmp++; if (st !== 2 || fch !== 1 || !fok || wbs !== 0) begin n_fail++; $display("FAIL store_miss: got stalls %0d fetch %0d ok %0d wb %0d expected 2/1/1/0", st, fch, fok, wbs); end
        ref_access(0, 1, 32'h00010005, 0, e_st, e_wb, e_wba, e_wbd, e_rd);
        do_access(0, 1, 32'h00010005, 0, st, wbs, wba, wbd, fch, fok, both, rd);
        n_cmp++; if (rd !== 32'hCAFEF00D || st !== 0) begin n_fail++; $display("FAIL store_miss_readback: got %h stalls %0d expected cafef00d/0", rd, st); end
        // Conflicting load proves the allocated line was left dirty.
        ref_access(0, 1, 32'h00010105, 0, e_st, e_wb, e_wba, e_wbd, e_rd);
        do_access(0, 1, 32'h00010105, 0, st, wbs, wba, wbd, fch, fok, both, rd);
        n_cmp++; if (st !== 3 || wbs !== 1 || wba !== 32'h00010005 || wbd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL store_miss_dirty: got stalls %0d wb %0d %h %h expected 3/1/00010005/cafef00d", st, wbs, wba, wbd); end
    endtask

    task automatic test_mmio();
        int st, wbs, fch, e_st, e_wb; bit fok, both; logic [31:0] wba, wbd, rd, e_wba, e_wbd, e_rd;
        ref_access(0, 1, 32'hFC, 0, e_st, e_wb, e_wba, e_wbd, e_rd);
        do_access(0, 1, 32'hFC, 0, st, wbs, wba, wbd, fch, fok, both, rd);
        n_cmp++; if (rd !== 32'h1 || st !== 0 || fch !== 0) begin n_fail++; $display("FAIL mmio_load: got %h stalls %0d fetch %0d expected 1/0/0", rd, st, fch); end
        cpu_re = 1'b1; cpu_addr = 32'hFC;
        @(negedge clk);
        n_cmp++; if (mem_addr !== 32'hFC || mem_fetch !== 1'b0) begin n_fail++; $display("FAIL mmio_mem_bus: got addr %h fetch %b expected fc/0", mem_addr, mem_fetch); end
        @(posedge clk); #1; cpu_re = 1'b0;
        ref_access(1, 0, 32'hFC, 32'h0BADBAD0, e_st, e_wb, e_wba, e_wbd, e_rd);
        do_access(1, 0, 32'hFC, 32'h0BADBAD0, st, wbs, wba, wbd, fch, fok, both, rd);
        n_cmp++; if (st !== 0 || wbs !== 0 || fch !== 0) begin n_fail++; $display("FAIL mmio_store: got stalls %0d wb %0d fetch %0d expected 0/0/0", st, wbs, fch); end
        do_access(0, 1, 32'hFC, 0, st, wbs, wba, wbd, fch, fok, both, rd);
        n_cmp++; if (rd !== 32'h1) begin n_fail++; $display("FAIL mmio_reload: got %h expected 1", rd); end
    endtask

    task automatic test_reset_mid_writeback();
        int st, wbs, fch, e_st, e_wb; bit fok, both; logic [31:0] wba, wbd, rd, e_wba, e_wbd, e_rd;
        ref_access(1, 0, 32'h00020007, 32'h77777777, e_st, e_wb, e_wba, e_wbd, e_rd);
        do_access(1, 0, 32'h00020007, 32'h77777777, st, wbs, wba, wbd, fch, fok, both, rd);
        cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h00020107;
        @(negedge clk);
        n_cmp++; if (stall !== 1'b1 || mem_writeback !== 1'b0) begin n_fail++; $display("FAIL rst_wb_miss_cycle: got stall %b wb %b expected 1/0", stall, mem_writeback); end
        @(posedge clk); @(negedge clk);
        n_cmp++; if (mem_writeback !== 1'b1 || mem_wb_addr !== 32'h00020007) begin n_fail++; $display("FAIL rst_wb_cycle: got wb %b addr %h expected 1/00020007", mem_writeback, mem_wb_addr); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (stall !== 1'b0 || mem_writeback !== 1'b0 || mem_fetch !== 1'b0) begin n_fail++; $display("FAIL rst_async_drop: got stall %b wb %b fetch %b expected 0/0/0", stall, mem_writeback, mem_fetch); end
        cpu_re = 1'b0;
        @(posedge clk); @(negedge clk); rst_n = 1'b1;
        ref_clear();
        @(posedge clk); #1;
        n_cmp++; if (rd_mem(32'h00020007) !== dflt(32'h00020007)) begin n_fail++; $display("FAIL rst_wb_not_written: got %h expected %h", rd_mem(32'h00020007), dflt(32'h00020007)); end
        ref_access(0, 1, 32'h00020007, 0, e_st, e_wb, e_wba, e_wbd, e_rd);
        do_access(0, 1, 32'h00020007, 0, st, wbs, wba, wbd, fch, fok, both, rd);
        n_cmp++; if (st !== 2 || wbs !== 0) begin n_fail++; $display("FAIL rst_reload_miss: got stalls %0d wb %0d expected 2/0", st, wbs); end
        n_cmp++; if (rd !== e_rd) begin n_fail++; $display("FAIL rst_reload_rdata: got %h expected %h", rd, e_rd); end
    endtask

    task automatic test_random();
        int st, wbs, fch, e_st, e_wb, op; bit fok, both; logic we, re;
        logic [31:0] wba, wbd, rd, e_wba, e_wbd, e_rd, addr, wdata;
        logic [31:0] idx_pool [5];
        idx_pool[0] = 32'h00; idx_pool[1] = 32'h01; idx_pool[2] = 32'h02;
        idx_pool[3] = 32'h05; idx_pool[4] = 32'hFC;
        for (int i = 0; i < 300; i++) begin
            addr  = 32'($urandom_range(0, 3)) * 32'd256 + idx_pool[$urandom_range(0, 4)];
            wdata = $urandom;
            op    = int'($urandom_range(0, 9));
            we    = (op >= 6);
            re    = (op >= 1 && op <= 5) || (op == 9);
            ref_access(we, re, addr, wdata, e_st, e_wb, e_wba, e_wbd, e_rd);
            do_access(we, re, addr, wdata, st, wbs, wba, wbd, fch, fok, both, rd);
            n_cmp++; if (st !== e_st) begin n_fail++; $display("FAIL rnd_stalls[%0d] addr %h we %b re %b: got %0d expected %0d", i, addr, we, re, st, e_st); end
            n_cmp++; if (wbs !== e_wb) begin n_fail++; $display("FAIL rnd_wb_count[%0d] addr %h: got %0d expected %0d", i, addr, wbs, e_wb); end
            if (e_wb == 1) begin
                n_cmp++; if (wba !== e_wba || wbd !== e_wbd) begin n_fail++; $display("FAIL rnd_wb_payload[%0d]: got %h/%h expected %h/%h", i, wba, wbd, e_wba, e_wbd); end
            end
            n_cmp++; if (fch !== (e_st > 0 ? 1 : 0) || !fok || both) begin n_fail++; $display("FAIL rnd_fetch[%0d] addr %h: got n %0d ok %0d overlap %0d expected %0d/1/0", i, addr, fch, fok, both, (e_st > 0 ? 1 : 0)); end
            n_cmp++; if (rd !== e_rd) begin n_fail++; $display("FAIL rnd_rdata[%0d] addr %h: got %h expected %h", i, addr, rd, e_rd); end
        end
    endtask

    initial begin
        mem[32'h00010000]     = 32'hDEADBEEF;
        ref_mem[32'h00010000] = 32'hDEADBEEF;
        mem[32'h000000FC]     = 32'h00000001;
        ref_mem[32'h000000FC] = 32'h00000001;
        pre_gen = 1;
        test_reset();
        test_load_miss_clean();
        test_store_hit();
        test_dirty_evict();
        test_store_miss();
        test_mmio();
        test_reset_mid_writeback();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
